// File: rtl/ifu_fetch_ctrl.sv
// Multi-cycle instruction fetch controller: owns the PC, issues one fetch at a time, hands words to decode.
// Optional feature macro: IFU_PERF_CNT_EN adds saturating fetch/stall performance counters.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [31:0]       mem_req_addr,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [31:0]       mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              fetch_err,
  input  logic              pc_wen,
  input  logic [31:0]       pc_wdata,
  input  logic              halt,
  output logic [PERF_W-1:0] perf_fetch_cnt,
  output logic [PERF_W-1:0] perf_stall_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    VALID,
    WAIT_PC,
    HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        err_q, err_d;
  logic        halt_pend_q, halt_pend_d;
  logic        rsp_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      inst_pc_q   <= RESET_PC;
      err_q       <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      err_q       <= err_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  // A halt seen mid-fetch is remembered so the in-flight word is still delivered before stopping.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    err_d       = err_q;
    halt_pend_d = halt_pend_q;
    rsp_fire    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = halt ? HALT : REQ;
      end
      REQ: begin
        if (halt) halt_pend_d = 1'b1;
        if (mem_req_ready) state_d = RESP;
      end
      RESP: begin
        if (halt) halt_pend_d = 1'b1;
        if (mem_rsp_valid) begin
          rsp_fire  = 1'b1;
          inst_d    = mem_rsp_data;
          inst_pc_d = pc_q;
          err_d     = mem_rsp_err;
          state_d   = VALID;
        end
      end
      VALID: begin
        if (inst_ready) begin
          if (halt || halt_pend_q) begin
            halt_pend_d = 1'b1;
            state_d     = WAIT_PC;
          end else if (pc_wen) begin
            pc_d    = pc_wdata;
            state_d = REQ;
          end else begin
            state_d = WAIT_PC;
          end
        end else if (halt) begin
          halt_pend_d = 1'b1;
        end
      end
      WAIT_PC: begin
        if (halt || halt_pend_q) begin
          state_d = HALT;
        end else if (pc_wen) begin
          pc_d    = pc_wdata;
          state_d = REQ;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_req_addr  = pc_q;
  assign mem_rsp_ready = (state_q == RESP);
  assign inst_valid    = (state_q == VALID);
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign fetch_err     = err_q;

`ifdef IFU_PERF_CNT_EN
  logic [PERF_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (rsp_fire && (fetch_cnt_q != {PERF_W{1'b1}})) fetch_cnt_d = fetch_cnt_q + 1'b1;
    if (((state_q == REQ) || (state_q == RESP)) && (stall_cnt_q != {PERF_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  logic unused_rsp_fire;
  assign unused_rsp_fire = rsp_fire;
  assign perf_fetch_cnt  = '0;
  assign perf_stall_cnt  = '0;
`endif

endmodule
